// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// requester IDs and default datapath widths.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StOwn     = 2'b01,
        StRelease = 2'b10
    } arb_state_e;

    // Requester IDs double as the Sel encoding of the steering muxes.
    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_LSU   = 1'b1;

    localparam int unsigned DEF_ADDR_W = 24;
    localparam int unsigned DEF_DATA_W = 24;

endpackage

// File: rtl/arb_timeout_counter.sv
// Transaction timeout counter for the memory port arbiter.
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   clr_i     : synchronous clear (has priority over inc_i)
//   inc_i     : increment by one
//   expired_o : count has reached TIMEOUT-1
module arb_timeout_counter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LastCnt);

endmodule

// File: rtl/mux2_cell.sv
// 1-bit 2:1 mux cell.
//   a0_i  : selected when sel_i = 0
//   a1_i  : selected when sel_i = 1
//   sel_i : select
//   y_o   : output
module mux2_cell (
    input  logic a0_i,
    input  logic a1_i,
    input  logic sel_i,
    output logic y_o
);

    assign y_o = sel_i ? a1_i : a0_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch
// (requester 0) and the load/store unit (requester 1).
//   Clock, Reset_n                : clock, asynchronous active-low reset
//   Req*/Addr*/WData*/We*         : requester front-end inputs
//   Gnt*/Done*                    : ownership level, one-cycle completion pulse
//   Err                           : timeout flag, coincident with Done
//   Sel                           : steering mux select (0 = fetch, 1 = LSU)
//   Mem_Req/Addr/WData/We, Mem_Ack: memory interface
//   Busy                          : a transaction is in flight
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Req0,
    input  logic              Req1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData0,
    input  logic [DATA_W-1:0] WData1,
    input  logic              We0,
    input  logic              We1,
    output logic              Gnt0,
    output logic              Gnt1,
    output logic              Done0,
    output logic              Done1,
    output logic              Err,
    output logic              Sel,
    output logic              Mem_Req,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_WData,
    output logic              Mem_We,
    input  logic              Mem_Ack,
    output logic              Busy
);

    localparam int unsigned MuxW = ADDR_W + DATA_W + 1;

    arb_state_e state_d, state_q;
    logic       sel_d, sel_q;
    logic       prio_d, prio_q;
    logic       err_d, err_q;
    logic       cnt_clr, cnt_inc, expired;
    logic       own, rel;

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i     (Clock),
        .rst_ni    (Reset_n),
        .clr_i     (cnt_clr),
        .inc_i     (cnt_inc),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        prio_d  = prio_q;
        err_d   = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            StIdle: begin
                if (Req0 || Req1) begin
                    state_d = StOwn;
                    if (Req0 && Req1) begin
                        sel_d = prio_q;
                    end else begin
                        sel_d = Req1 ? REQ_LSU : REQ_FETCH;
                    end
                end
            end
            StOwn: begin
                cnt_inc = 1'b1;
                // An ack in the expiry cycle completes normally.
                if (Mem_Ack) begin
                    state_d = StRelease;
                end else if (expired) begin
                    state_d = StRelease;
                    err_d   = 1'b1;
                end
            end
            StRelease: begin
                cnt_clr = 1'b1;
                prio_d  = ~sel_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            sel_q   <= REQ_FETCH;
            prio_q  <= REQ_FETCH;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            prio_q  <= prio_d;
            err_q   <= err_d;
        end
    end

    assign own     = (state_q == StOwn);
    assign rel     = (state_q == StRelease);
    assign Gnt0    = own & ~sel_q;
    assign Gnt1    = own & sel_q;
    assign Done0   = rel & ~sel_q;
    assign Done1   = rel & sel_q;
    assign Err     = err_q;
    assign Sel     = sel_q;
    assign Mem_Req = own;
    assign Busy    = (state_q != StIdle);

    // Address, write data and write enable share one bank of mux cells.
    logic [MuxW-1:0] mux_in0, mux_in1, mux_out;

    assign mux_in0 = {Addr0, WData0, We0};
    assign mux_in1 = {Addr1, WData1, We1};

    for (genvar i = 0; i < MuxW; i++) begin : g_steer
        mux2_cell u_mux (
            .a0_i  (mux_in0[i]),
            .a1_i  (mux_in1[i]),
            .sel_i (sel_q),
            .y_o   (mux_out[i])
        );
    end

    assign Mem_Addr  = mux_out[MuxW-1 -: ADDR_W];
    assign Mem_WData = mux_out[DATA_W:1];
    assign Mem_We    = mux_out[0] & own;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW = 24;
    localparam int DW = 24;
    localparam int TO = 4;

    logic          Clock = 1'b0;
    logic          Reset_n = 1'b1;
    logic          Req0 = 0, Req1 = 0, We0 = 0, We1 = 0, Mem_Ack = 0;
    logic [AW-1:0] Addr0 = '0, Addr1 = '0;
    logic [DW-1:0] WData0 = '0, WData1 = '0;
    logic          Gnt0, Gnt1, Done0, Done1, Err, Sel, Mem_Req, Mem_We, Busy;
    logic [AW-1:0] Mem_Addr;
    logic [DW-1:0] Mem_WData;

    mem_port_arbiter #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Req0      (Req0),
        .Req1      (Req1),
        .Addr0     (Addr0),
        .Addr1     (Addr1),
        .WData0    (WData0),
        .WData1    (WData1),
        .We0       (We0),
        .We1       (We1),
        .Gnt0      (Gnt0),
        .Gnt1      (Gnt1),
        .Done0     (Done0),
        .Done1     (Done1),
        .Err       (Err),
        .Sel       (Sel),
        .Mem_Req   (Mem_Req),
        .Mem_Addr  (Mem_Addr),
        .Mem_WData (Mem_WData),
        .Mem_We    (Mem_We),
        .Mem_Ack   (Mem_Ack),
        .Busy      (Busy)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction-level reference: is a transaction holding the port, is one
    // finishing this cycle, who owns it, how many cycles it has waited.
    bit m_own, m_rel, m_err, m_prio, m_sel;
    int m_owner, m_age;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_rel = 0; m_err = 0; m_prio = 0; m_sel = 0;
        m_owner = 0; m_age = 0;
    endtask

    // Advance one clock edge using the inputs the DUT sampled.
    task automatic model_step();
        if (m_rel) begin
            m_rel  = 0;
            m_err  = 0;
            m_prio = (m_owner == 0);
        end else if (m_own) begin
            if (Mem_Ack) begin
                m_own = 0; m_rel = 1; m_err = 0;
            end else if (m_age == TO - 1) begin
                m_own = 0; m_rel = 1; m_err = 1;
            end else begin
                m_age++;
            end
        end else if (Req0 || Req1) begin
            if (Req0 && Req1) m_owner = m_prio ? 1 : 0;
            else              m_owner = Req1 ? 1 : 0;
            m_sel = (m_owner == 1);
            m_own = 1;
            m_age = 0;
        end
    endtask

    task automatic check_all();
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_we;
        e_addr  = m_sel ? Addr1 : Addr0;
        e_wdata = m_sel ? WData1 : WData0;
        e_we    = m_own && (m_sel ? We1 : We0);
        check("gnt0",  32'(Gnt0),    32'(m_own && m_owner == 0));
        check("gnt1",  32'(Gnt1),    32'(m_own && m_owner == 1));
        check("done0", 32'(Done0),   32'(m_rel && m_owner == 0));
        check("done1", 32'(Done1),   32'(m_rel && m_owner == 1));
        check("err",   32'(Err),     32'(m_rel && m_err));
        check("sel",   32'(Sel),     32'(m_sel));
        check("mreq",  32'(Mem_Req), 32'(m_own));
        check("busy",  32'(Busy),    32'(m_own || m_rel));
        check("maddr", 32'(Mem_Addr),  32'(e_addr));
        check("mwdat", 32'(Mem_WData), 32'(e_wdata));
        check("mwe",   32'(Mem_We),    32'(e_we));
    endtask

    // dir: 0 random data, 1 fetch reads 24'h000100, 2 LSU write ABCDEF to FFFFFE.
    // ack: 0 never, 1 always, 2 random, 3 exactly in the expiry cycle.
    task automatic drive(input int p0, input int p1, input int ack, input int dir);
        Req0 = ($urandom_range(99) < p0);
        Req1 = ($urandom_range(99) < p1);
        if (!(m_own && m_owner == 0)) begin
            Addr0  = (dir == 1) ? 24'h000100 : AW'($urandom);
            WData0 = DW'($urandom);
            We0    = (dir == 1) ? 1'b0 : 1'($urandom);
        end
        if (!(m_own && m_owner == 1)) begin
            Addr1  = (dir == 2) ? 24'hFFFFFE : AW'($urandom);
            WData1 = (dir == 2) ? 24'hABCDEF : DW'($urandom);
            We1    = (dir == 2) ? 1'b1 : 1'($urandom);
        end
        case (ack)
            0:       Mem_Ack = 1'b0;
            1:       Mem_Ack = 1'b1;
            2:       Mem_Ack = ($urandom_range(99) < 30);
            default: Mem_Ack = m_own && (m_age == TO - 1);
        endcase
    endtask

    task automatic run_phase(input int n, input int p0, input int p1, input int ack,
                             input int dir);
        repeat (n) begin
            @(posedge Clock);
            model_step();
            @(negedge Clock);
            check_all();
            drive(p0, p1, ack, dir);
        end
    endtask

    initial begin
        bit found;
        model_reset();
        #1 Reset_n = 1'b0;
        #1 check_all();
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;

        run_phase(20, 100, 0, 1, 1);     // single fetch requester, zero-wait ack
        run_phase(30, 100, 100, 1, 0);   // continuous contention
        run_phase(20, 0, 100, 2, 2);     // LSU write steering
        run_phase(30, 100, 0, 0, 0);     // timeouts only
        run_phase(30, 70, 70, 3, 0);     // ack lands on the expiry cycle
        run_phase(300, 50, 50, 2, 0);    // mixed traffic

        // Reset while the LSU owns the port.
        found = 0;
        drive(0, 100, 0, 0);
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge Clock);
            model_step();
            @(negedge Clock);
            check_all();
            drive(0, 100, 0, 0);
            if (m_own && m_owner == 1 && m_age >= 1) found = 1;
        end
        check("rst_setup", 32'(found), 32'd1);
        #2 Reset_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge Clock);
        check_all();
        Req1 = 1'b0;
        Reset_n = 1'b1;
        run_phase(100, 60, 60, 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
